typer_sequencer: RTL and testbench

TYPER_SEQUENCER -- requirements
Module: typer_sequencer

---
 rtl/typer_sequencer_pkg.sv | 23 ++
 rtl/typer_sequencer_key.sv | 53 +++++
 rtl/typer_sequencer.sv | 153 +++++++++++++++
 tb/tb_typer_sequencer.sv | 330 +++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/typer_sequencer_pkg.sv
// Shared definitions for the typing sequencer: FSM encoding, ASCII codes and
// default text-grid geometry.
package typer_sequencer_pkg;

    localparam int NUM_COLS_DEFAULT = 32;
    localparam int NUM_ROWS_DEFAULT = 7;

    localparam logic [1:0] ST_IDLE      = 2'd0;
    localparam logic [1:0] ST_ISSUE     = 2'd1;
    localparam logic [1:0] ST_WAIT_ACK  = 2'd2;
    localparam logic [1:0] ST_WAIT_DONE = 2'd3;

    localparam logic [7:0] ASCII_BACKSPACE = 8'h08;
    localparam logic [7:0] ASCII_NEWLINE   = 8'h0A;
    localparam logic [7:0] ASCII_SPACE     = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MIN = 8'h20;
    localparam logic [7:0] ASCII_PRINT_MAX = 8'h7E;

    function automatic logic is_printable(input logic [7:0] code);
        return (code >= ASCII_PRINT_MIN) && (code <= ASCII_PRINT_MAX);
    endfunction

endpackage

// File: rtl/typer_sequencer_key.sv
// Keystroke buffer: synchronous first-word-fall-through FIFO with full/empty flags.
// DEPTH must be a power of two so the pointers wrap naturally.
module key_fifo #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);

    localparam int PTR_W   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int COUNT_W = PTR_W + 1;

    logic [WIDTH-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]   wr_ptr;
    logic [PTR_W-1:0]   rd_ptr;
    logic [COUNT_W-1:0] count;
    logic               do_push;
    logic               do_pop;

    assign full     = (count == COUNT_W'(DEPTH));
    assign empty    = (count == '0);
    assign do_push  = push && !full;
    assign do_pop   = pop && !empty;
    assign pop_data = mem[rd_ptr];

    always_ff @(posedge clock) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + 1'b1;
            if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/typer_sequencer.sv
// Turns buffered keystrokes into one-at-a-time character writes for the typer,
// tracking the text cursor across a NUM_ROWS x NUM_COLS grid.
module typer_sequencer
    import typer_sequencer_pkg::*;
#(
    parameter int NUM_COLS   = NUM_COLS_DEFAULT,
    parameter int NUM_ROWS   = NUM_ROWS_DEFAULT,
    parameter int FIFO_DEPTH = 4
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       key_valid,
    input  logic [7:0] key_code,
    output logic       key_ready,
    input  logic       finished_saving_char,
    output logic       start_writing_character,
    output logic [7:0] row_num,
    output logic [7:0] col_num,
    output logic [7:0] character_input,
    output logic [7:0] cursor_row,
    output logic [7:0] cursor_col,
    output logic       busy
);

    localparam logic [7:0] LAST_COL = 8'(NUM_COLS - 1);
    localparam logic [7:0] LAST_ROW = 8'(NUM_ROWS - 1);

    logic [1:0] state;
    logic       issue_write;
    logic [7:0] next_row;
    logic [7:0] next_col;

    logic       fifo_full;
    logic       fifo_empty;
    logic       fifo_pop;
    logic [7:0] head_code;

    logic       dec_write;
    logic [7:0] dec_char;
    logic [7:0] dec_wr_row;
    logic [7:0] dec_wr_col;
    logic [7:0] dec_next_row;
    logic [7:0] dec_next_col;
    logic [7:0] row_inc;

    assign key_ready               = !fifo_full;
    assign fifo_pop                = (state == ST_IDLE) && !fifo_empty && finished_saving_char;
    assign start_writing_character = (state == ST_ISSUE) && issue_write;
    assign busy                    = (state != ST_IDLE);

    key_fifo #(
        .WIDTH (8),
        .DEPTH (FIFO_DEPTH)
    ) u_key_fifo (
        .clock     (clock),
        .reset     (reset),
        .push      (key_valid && key_ready),
        .push_data (key_code),
        .pop       (fifo_pop),
        .pop_data  (head_code),
        .full      (fifo_full),
        .empty     (fifo_empty)
    );

    // Decode the head keystroke against the current cursor: where (if anywhere)
    // to write, and where the cursor lands once the write completes.
    always_comb begin
        row_inc      = (cursor_row == LAST_ROW) ? 8'd0 : cursor_row + 8'd1;
        dec_write    = 1'b0;
        dec_char     = head_code;
        dec_wr_row   = cursor_row;
        dec_wr_col   = cursor_col;
        dec_next_row = cursor_row;
        dec_next_col = cursor_col;
        if (is_printable(head_code)) begin
            dec_write = 1'b1;
            if (cursor_col == LAST_COL) begin
                dec_next_col = 8'd0;
                dec_next_row = row_inc;
            end else begin
                dec_next_col = cursor_col + 8'd1;
            end
        end else if (head_code == ASCII_NEWLINE) begin
            dec_next_col = 8'd0;
            dec_next_row = row_inc;
        end else if (head_code == ASCII_BACKSPACE &&
                     !(cursor_row == 8'd0 && cursor_col == 8'd0)) begin
            dec_write = 1'b1;
            dec_char  = ASCII_SPACE;
            if (cursor_col == 8'd0) begin
                dec_wr_row = cursor_row - 8'd1;
                dec_wr_col = LAST_COL;
            end else begin
                dec_wr_col = cursor_col - 8'd1;
            end
            dec_next_row = dec_wr_row;
            dec_next_col = dec_wr_col;
        end
    end

    // Non-writing keystrokes still pass through ISSUE for one cycle and apply
    // their cursor change there; writes defer it until the typer reports done.
    always_ff @(posedge clock) begin
        if (reset) begin
            state           <= ST_IDLE;
            issue_write     <= 1'b0;
            next_row        <= 8'd0;
            next_col        <= 8'd0;
            cursor_row      <= 8'd0;
            cursor_col      <= 8'd0;
            row_num         <= 8'd0;
            col_num         <= 8'd0;
            character_input <= 8'd0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (fifo_pop) begin
                        state       <= ST_ISSUE;
                        issue_write <= dec_write;
                        next_row    <= dec_next_row;
                        next_col    <= dec_next_col;
                        if (dec_write) begin
                            row_num         <= dec_wr_row;
                            col_num         <= dec_wr_col;
                            character_input <= dec_char;
                        end
                    end
                end
                ST_ISSUE: begin
                    if (issue_write) begin
                        state <= ST_WAIT_ACK;
                    end else begin
                        cursor_row <= next_row;
                        cursor_col <= next_col;
                        state      <= ST_IDLE;
                    end
                end
                ST_WAIT_ACK: begin
                    if (!finished_saving_char) state <= ST_WAIT_DONE;
                end
                ST_WAIT_DONE: begin
                    if (finished_saving_char) begin
                        cursor_row <= next_row;
                        cursor_col <= next_col;
                        state      <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_typer_sequencer.sv
// Self-checking bench: directed scenarios plus random keystrokes, compared against
// a linear-position cursor model and a queue of expected typer writes.
module tb_typer_sequencer;

    localparam int COLS = 32;
    localparam int ROWS = 7;

    typedef struct packed {
        logic [7:0] row;
        logic [7:0] col;
        logic [7:0] chr;
    } write_t;

    logic       clock = 1'b0;
    logic       reset;
    logic       key_valid;
    logic [7:0] key_code;
    logic       key_ready;
    logic       finished_saving_char;
    logic       start_writing_character;
    logic [7:0] row_num;
    logic [7:0] col_num;
    logic [7:0] character_input;
    logic [7:0] cursor_row;
    logic [7:0] cursor_col;
    logic       busy;

    int     assert_count = 0;
    int     fail_count   = 0;
    int     start_count  = 0;
    bit     hold_busy    = 1'b0;
    int     model_row    = 0;
    int     model_col    = 0;
    write_t exp_q[$];

    typer_sequencer #(
        .NUM_COLS   (COLS),
        .NUM_ROWS   (ROWS),
        .FIFO_DEPTH (4)
    ) dut (
        .clock                   (clock),
        .reset                   (reset),
        .key_valid               (key_valid),
        .key_code                (key_code),
        .key_ready               (key_ready),
        .finished_saving_char    (finished_saving_char),
        .start_writing_character (start_writing_character),
        .row_num                 (row_num),
        .col_num                 (col_num),
        .character_input         (character_input),
        .cursor_row              (cursor_row),
        .cursor_col              (cursor_col),
        .busy                    (busy)
    );

    always #5 clock = ~clock;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] want);
        assert_count++;
        if (got !== want) begin
            fail_count++;
            $display("[TB] FAIL %s: got %0h, expected %0h", tag, got, want);
        end
    endtask

    // Reference model: cursor as a linear position on the grid.
    task automatic modelKey(input logic [7:0] code);
        int     pos;
        write_t w;
        pos = model_row * COLS + model_col;
        if (code >= 8'h20 && code <= 8'h7E) begin
            w.row = 8'(model_row); w.col = 8'(model_col); w.chr = code;
            exp_q.push_back(w);
            pos       = (pos + 1) % (COLS * ROWS);
            model_row = pos / COLS;
            model_col = pos % COLS;
        end else if (code == 8'h0A) begin
            model_row = (model_row + 1) % ROWS;
            model_col = 0;
        end else if (code == 8'h08 && pos != 0) begin
            pos       = pos - 1;
            model_row = pos / COLS;
            model_col = pos % COLS;
            w.row = 8'(model_row); w.col = 8'(model_col); w.chr = 8'h20;
            exp_q.push_back(w);
        end
    endtask

    // Called at a negedge; offers one keystroke for one cycle.
    task automatic applyStimulus(input logic [7:0] code, output bit accepted);
        key_valid = 1'b1;
        key_code  = code;
        accepted  = key_ready;
        @(negedge clock);
        key_valid = 1'b0;
        if (accepted) modelKey(code);
    endtask

    task automatic pushKey(input logic [7:0] code);
        bit ok;
        int tries;
        ok    = 1'b0;
        tries = 0;
        while (!ok && tries < 300) begin
            applyStimulus(code, ok);
            tries++;
        end
        checkOutput("push_accepted", ok, 1);
    endtask

    task automatic waitDrain();
        int idle_run;
        int cyc;
        idle_run = 0;
        cyc      = 0;
        while (idle_run < 3 && cyc < 5000) begin
            @(negedge clock);
            cyc++;
            if (!busy && finished_saving_char && !hold_busy) idle_run++;
            else idle_run = 0;
        end
        checkOutput("drain_done", idle_run, 3);
        checkOutput("exp_writes_left", exp_q.size(), 0);
    endtask

    task automatic checkCursor(input string tag);
        checkOutput({tag, "_row"}, cursor_row, model_row);
        checkOutput({tag, "_col"}, cursor_col, model_col);
    endtask

    task automatic doReset();
        reset     = 1'b1;
        key_valid = 1'b0;
        repeat (2) @(negedge clock);
        reset     = 1'b0;
        model_row = 0;
        model_col = 0;
        exp_q.delete();
    endtask

    task automatic moveTo(input int row, input int col);
        doReset();
        for (int i = 0; i < row; i++) pushKey(8'h0A);
        for (int i = 0; i < col; i++) pushKey(8'h2E);
        waitDrain();
    endtask

    // Typer model: takes each start pulse, drops the idle flag for a random time,
    // and checks the write against the expected queue.
    initial begin
        write_t got;
        int     lat;
        finished_saving_char = 1'b1;
        forever begin
            @(negedge clock);
            if (start_writing_character === 1'b1) begin
                start_count++;
                got.row = row_num; got.col = col_num; got.chr = character_input;
                checkOutput("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) begin
                    checkOutput("write_pos_char", got, exp_q.pop_front());
                end
                finished_saving_char = 1'b0;
                lat = $urandom_range(2, 6);
                for (int i = 0; i < lat || (hold_busy && i < 5000); i++) begin
                    @(negedge clock);
                    checkOutput("single_pulse", start_writing_character, 0);
                    if (busy) begin
                        checkOutput("hold_row", row_num, got.row);
                        checkOutput("hold_col", col_num, got.col);
                        checkOutput("hold_char", character_input, got.chr);
                    end
                end
                finished_saving_char = 1'b1;
            end else begin
                finished_saving_char = !hold_busy;
            end
        end
    end

    initial begin
        #800000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int  s;
        bit  ok;
        int  r;
        logic [7:0] code;

        reset     = 1'b1;
        key_valid = 1'b0;
        key_code  = 8'h00;
        repeat (2) @(negedge clock);
        checkOutput("reset_busy", busy, 0);
        checkOutput("reset_start", start_writing_character, 0);
        checkOutput("reset_row_num", row_num, 0);
        checkOutput("reset_col_num", col_num, 0);
        checkOutput("reset_char", character_input, 0);
        checkOutput("reset_cursor_row", cursor_row, 0);
        checkOutput("reset_cursor_col", cursor_col, 0);
        reset = 1'b0;
        @(negedge clock);
        checkOutput("reset_key_ready", key_ready, 1);

        // Single printable key.
        s = start_count;
        pushKey(8'h41);
        waitDrain();
        checkOutput("A_pulses", start_count - s, 1);
        checkOutput("A_cursor_row", cursor_row, 0);
        checkOutput("A_cursor_col", cursor_col, 1);

        // End-of-row wrap and bottom-of-region wrap.
        moveTo(0, 31);
        checkCursor("pre_wrap");
        pushKey(8'h42);
        waitDrain();
        checkOutput("wrap_row", cursor_row, 1);
        checkOutput("wrap_col", cursor_col, 0);
        moveTo(6, 31);
        pushKey(8'h43);
        waitDrain();
        checkOutput("bottom_wrap_row", cursor_row, 0);
        checkOutput("bottom_wrap_col", cursor_col, 0);

        // Backspace across a row boundary, and at the origin.
        moveTo(2, 0);
        s = start_count;
        pushKey(8'h08);
        waitDrain();
        checkOutput("bs_pulses", start_count - s, 1);
        checkOutput("bs_row", cursor_row, 1);
        checkOutput("bs_col", cursor_col, 31);
        doReset();
        s = start_count;
        pushKey(8'h08);
        waitDrain();
        checkOutput("bs_origin_pulses", start_count - s, 0);
        checkCursor("bs_origin");

        // Newline and an ignored control code.
        moveTo(3, 17);
        s = start_count;
        pushKey(8'h0A);
        waitDrain();
        checkOutput("nl_pulses", start_count - s, 0);
        checkOutput("nl_row", cursor_row, 4);
        checkOutput("nl_col", cursor_col, 0);
        pushKey(8'h07);
        waitDrain();
        checkOutput("bel_pulses", start_count - s, 0);
        checkOutput("bel_row", cursor_row, 4);
        checkOutput("bel_col", cursor_col, 0);

        // Back-pressure: typer busy, five offers, only four fit.
        doReset();
        hold_busy = 1'b1;
        repeat (3) @(negedge clock);
        for (int k = 0; k < 5; k++) begin
            applyStimulus(8'(8'h61 + k), ok);
            checkOutput("full_accept", ok, (k < 4));
        end
        checkOutput("full_key_ready", key_ready, 0);
        s = start_count;
        hold_busy = 1'b0;
        waitDrain();
        checkOutput("full_pulses", start_count - s, 4);
        checkCursor("full");

        // Reset while waiting for the typer to finish.
        doReset();
        s = start_count;
        pushKey(8'h41);
        for (int i = 0; i < 50 && start_count == s; i++) @(negedge clock);
        checkOutput("rst_start_seen", start_count - s, 1);
        hold_busy = 1'b1;
        repeat (4) @(negedge clock);
        checkOutput("rst_in_wait_done", busy, 1);
        doReset();
        checkOutput("rst_busy", busy, 0);
        checkOutput("rst_start", start_writing_character, 0);
        checkOutput("rst_row_num", row_num, 0);
        checkOutput("rst_col_num", col_num, 0);
        checkOutput("rst_char", character_input, 0);
        checkOutput("rst_cursor_row", cursor_row, 0);
        checkOutput("rst_cursor_col", cursor_col, 0);
        checkOutput("rst_key_ready", key_ready, 1);
        s = start_count;
        pushKey(8'h42);
        repeat (6) @(negedge clock);
        checkOutput("rst_no_start", start_count - s, 0);
        checkOutput("rst_idle_wait", busy, 0);
        hold_busy = 1'b0;
        waitDrain();
        checkOutput("rst_resume_pulses", start_count - s, 1);
        checkCursor("rst_resume");

        // Random keystroke mix.
        doReset();
        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            if (r < 55) begin
                code = 8'($urandom_range(32, 126));
            end else if (r < 65) begin
                code = 8'h0A;
            end else if (r < 85) begin
                code = 8'h08;
            end else begin
                code = ($urandom_range(0, 1) == 1) ? 8'($urandom_range(0, 31))
                                                   : 8'($urandom_range(127, 255));
                if (code == 8'h08 || code == 8'h0A) code = 8'h1B;
            end
            pushKey(code);
            if ($urandom_range(0, 3) == 0) repeat ($urandom_range(1, 8)) @(negedge clock);
            if (n % 50 == 49) begin
                waitDrain();
                checkCursor("rand");
            end
        end
        waitDrain();
        checkCursor("rand_final");

        $display("End of test - %0d assertions evaluated, %0d failures", assert_count, fail_count);
        $finish;
    end

endmodule
